// File: rtl/arena_move_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arena_move_arbiter                                                          |
// | Round-robin owner of the arena/bomb map write path for players A and B;     |
// | runs read-check-write per request and keeps authoritative coordinates.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module arena_move_arbiter #(
  parameter int GRID      = 10,
  parameter int MAX_BOMBS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [2:0] cmd_a,
  input  logic [2:0] cmd_b,
  input  logic       bomb_done_a,
  input  logic       bomb_done_b,
  output logic [3:0] rd_x,
  output logic [3:0] rd_y,
  input  logic [1:0] rd_arena,
  input  logic [1:0] rd_bomb,
  output logic       wr_en,
  output logic [3:0] wr_x,
  output logic [3:0] wr_y,
  output logic [1:0] wr_data,
  output logic       bomb_wr,
  output logic [3:0] bomb_x,
  output logic [3:0] bomb_y,
  output logic       bomb_owner,
  output logic       ack_a,
  output logic       ack_b,
  output logic       ok,
  output logic [3:0] pax,
  output logic [3:0] pay,
  output logic [3:0] pbx,
  output logic [3:0] pby,
  output logic       busy
);

  localparam logic [2:0] c_CMD_UP    = 3'd0;
  localparam logic [2:0] c_CMD_DOWN  = 3'd1;
  localparam logic [2:0] c_CMD_LEFT  = 3'd2;
  localparam logic [2:0] c_CMD_RIGHT = 3'd3;
  localparam logic [2:0] c_CMD_BOMB  = 3'd4;
  localparam logic [3:0] c_LAST      = 4'(GRID - 1);
  localparam logic [3:0] c_START_B   = 4'(GRID - 2);
  localparam logic [1:0] c_MAX_BOMBS = 2'(MAX_BOMBS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_CHK    = 3'd2,
    S_WR_CLR = 3'd3,
    S_WR_SET = 3'd4,
    S_BOMB   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t     r_state;
  logic       r_who;
  logic       r_lastB;
  logic       r_isBomb;
  logic       r_bad;
  logic [3:0] r_oldX, r_oldY, r_tgtX, r_tgtY;
  logic [1:0] r_bombCnt [2];

  logic       w_grant, w_grantB;
  logic [2:0] w_cmd;
  logic [3:0] w_curX, w_curY, w_tgtX, w_tgtY;
  logic       w_bad;
  logic [1:0] w_cnt;
  logic [1:0] w_place, w_done;

  // B wins a tie only when A was the last one served.
  assign w_grant  = enable && (req_a || req_b);
  assign w_grantB = req_b && (!req_a || !r_lastB);
  assign w_cmd    = w_grantB ? cmd_b : cmd_a;
  assign w_curX   = w_grantB ? pbx : pax;
  assign w_curY   = w_grantB ? pby : pay;
  assign w_cnt    = r_bombCnt[r_who];
  assign w_done   = {bomb_done_b, bomb_done_a};
  assign w_place  = {(r_state == S_BOMB) && r_who, (r_state == S_BOMB) && !r_who};

  always_comb begin
    w_tgtX = w_curX;
    w_tgtY = w_curY;
    w_bad  = 1'b0;
    case (w_cmd)
      c_CMD_UP:    if (w_curY == 4'd0)   w_bad = 1'b1; else w_tgtY = w_curY - 4'd1;
      c_CMD_DOWN:  if (w_curY >= c_LAST) w_bad = 1'b1; else w_tgtY = w_curY + 4'd1;
      c_CMD_LEFT:  if (w_curX == 4'd0)   w_bad = 1'b1; else w_tgtX = w_curX - 4'd1;
      c_CMD_RIGHT: if (w_curX >= c_LAST) w_bad = 1'b1; else w_tgtX = w_curX + 4'd1;
      c_CMD_BOMB:  w_bad = 1'b0;
      default:     w_bad = 1'b1;
    endcase
  end

  // A placement and an explosion in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) r_bombCnt[p] <= 2'd0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_place[p] && !w_done[p])
          r_bombCnt[p] <= r_bombCnt[p] + 2'd1;
        else if (!w_place[p] && w_done[p] && (r_bombCnt[p] != 2'd0))
          r_bombCnt[p] <= r_bombCnt[p] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_who      <= 1'b0;
      r_lastB    <= 1'b1;
      r_isBomb   <= 1'b0;
      r_bad      <= 1'b0;
      r_oldX     <= 4'd0;
      r_oldY     <= 4'd0;
      r_tgtX     <= 4'd0;
      r_tgtY     <= 4'd0;
      rd_x       <= 4'd0;
      rd_y       <= 4'd0;
      wr_en      <= 1'b0;
      wr_x       <= 4'd0;
      wr_y       <= 4'd0;
      wr_data    <= 2'd0;
      bomb_wr    <= 1'b0;
      bomb_x     <= 4'd0;
      bomb_y     <= 4'd0;
      bomb_owner <= 1'b0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      ok         <= 1'b0;
      busy       <= 1'b0;
      pax        <= 4'd1;
      pay        <= 4'd1;
      pbx        <= c_START_B;
      pby        <= c_START_B;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state  <= S_RD;
            busy     <= 1'b1;
            r_who    <= w_grantB;
            r_lastB  <= w_grantB;
            r_isBomb <= (w_cmd == c_CMD_BOMB);
            r_bad    <= w_bad;
            r_oldX   <= w_curX;
            r_oldY   <= w_curY;
            r_tgtX   <= w_tgtX;
            r_tgtY   <= w_tgtY;
            // Out-of-range targets never reach the map read port.
            if (!w_bad) begin
              rd_x <= w_tgtX;
              rd_y <= w_tgtY;
            end
          end
        end
        S_RD: begin
          if (r_bad) begin
            r_state <= S_DONE;
            ack_a   <= !r_who;
            ack_b   <= r_who;
            ok      <= 1'b0;
          end else begin
            r_state <= S_CHK;
          end
        end
        S_CHK: begin
          if (r_isBomb && (rd_bomb == 2'd0) && (w_cnt < c_MAX_BOMBS)) begin
            r_state    <= S_BOMB;
            bomb_wr    <= 1'b1;
            bomb_x     <= r_oldX;
            bomb_y     <= r_oldY;
            bomb_owner <= r_who;
          end else if (!r_isBomb && (rd_arena == 2'd0) && (rd_bomb == 2'd0)) begin
            r_state <= S_WR_CLR;
            wr_en   <= 1'b1;
            wr_x    <= r_oldX;
            wr_y    <= r_oldY;
            wr_data <= 2'd0;
          end else begin
            r_state <= S_DONE;
            ack_a   <= !r_who;
            ack_b   <= r_who;
            ok      <= 1'b0;
          end
        end
        S_WR_CLR: begin
          r_state <= S_WR_SET;
          wr_x    <= r_tgtX;
          wr_y    <= r_tgtY;
          wr_data <= r_who ? 2'd3 : 2'd2;
        end
        S_WR_SET: begin
          r_state <= S_DONE;
          wr_en   <= 1'b0;
          ack_a   <= !r_who;
          ack_b   <= r_who;
          ok      <= 1'b1;
          if (r_who) begin
            pbx <= r_tgtX;
            pby <= r_tgtY;
          end else begin
            pax <= r_tgtX;
            pay <= r_tgtY;
          end
        end
        S_BOMB: begin
          r_state <= S_DONE;
          bomb_wr <= 1'b0;
          ack_a   <= !r_who;
          ack_b   <= r_who;
          ok      <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          ack_a   <= 1'b0;
          ack_b   <= 1'b0;
          ok      <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          wr_en   <= 1'b0;
          bomb_wr <= 1'b0;
          ack_a   <= 1'b0;
          ack_b   <= 1'b0;
          ok      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arena_move_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arena_move_arbiter                                                       |
// | Transaction-level model of the arbiter plus a small map memory around it.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_arena_move_arbiter;
  localparam int GRID = 10;
  localparam int NCYC = 4096;

  logic       clk = 1'b0;
  logic       rst, enable, req_a, req_b, bomb_done_a, bomb_done_b;
  logic [2:0] cmd_a, cmd_b;
  logic [3:0] rd_x, rd_y, wr_x, wr_y, bomb_x, bomb_y, pax, pay, pbx, pby;
  logic [1:0] rd_arena, rd_bomb, wr_data;
  logic       wr_en, bomb_wr, bomb_owner, ack_a, ack_b, ok, busy;

  arena_move_arbiter #(.GRID(GRID), .MAX_BOMBS(3)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_a(req_a), .req_b(req_b), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .bomb_done_a(bomb_done_a), .bomb_done_b(bomb_done_b),
    .rd_x(rd_x), .rd_y(rd_y), .rd_arena(rd_arena), .rd_bomb(rd_bomb),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .bomb_wr(bomb_wr), .bomb_x(bomb_x), .bomb_y(bomb_y), .bomb_owner(bomb_owner),
    .ack_a(ack_a), .ack_b(ack_b), .ok(ok),
    .pax(pax), .pay(pay), .pbx(pbx), .pby(pby), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Map memory: initialised while reset is held, written by the DUT strobes.
  bit   blkOn;
  int   blkX, blkY;
  logic [1:0] envArena [GRID][GRID];
  logic [1:0] envBomb  [GRID][GRID];
  always @(posedge clk) begin
    rd_arena <= (rd_x < GRID && rd_y < GRID) ? envArena[rd_x][rd_y] : 2'd0;
    rd_bomb  <= (rd_x < GRID && rd_y < GRID) ? envBomb[rd_x][rd_y]  : 2'd0;
    if (!rst) begin
      for (int i = 0; i < GRID; i++)
        for (int j = 0; j < GRID; j++) begin
          envArena[i][j] <= 2'd0;
          envBomb[i][j]  <= 2'd0;
        end
      envArena[1][1] <= 2'd2;
      envArena[GRID-2][GRID-2] <= 2'd3;
      if (blkOn) envArena[blkX][blkY] <= 2'd1;
    end else begin
      if (wr_en && wr_x < GRID && wr_y < GRID) envArena[wr_x][wr_y] <= wr_data;
      if (bomb_wr && bomb_x < GRID && bomb_y < GRID) envBomb[bomb_x][bomb_y] <= 2'd1 + {1'b0, bomb_owner};
    end
  end

  // Expected per-cycle outputs, filled in whole when a request is granted.
  bit eBusy [NCYC], eWr [NCYC], eBw [NCYC], eAckA [NCYC], eAckB [NCYC], eOk [NCYC];
  bit eRdV [NCYC], ePosV [NCYC];
  int eWrX [NCYC], eWrY [NCYC], eWrD [NCYC], eBx [NCYC], eBy [NCYC], eBo [NCYC];
  int eRdX [NCYC], eRdY [NCYC], ePosP [NCYC], ePosX [NCYC], ePosY [NCYC];

  int mX [2], mY [2], mCnt [2], dX [2], dY [2];
  int mArena [GRID][GRID], mBomb [GRID][GRID];
  bit mLastB;
  int mFree;
  int ackCnt [2], lastAck [2], lastOk [2];
  int ackLog [$];

  always @(negedge clk) begin
    int c, p, cmd, x, y, tx, ty, lat;
    bit bad, okv;
    c = cyc;
    if (c < NCYC - 16) begin
      if (!rst) begin
        mX[0] = 1; mY[0] = 1; mX[1] = GRID - 2; mY[1] = GRID - 2;
        dX = mX; dY = mY;
        mCnt[0] = 0; mCnt[1] = 0;
        mLastB = 1'b1;
        mFree = c;
        for (int i = 0; i < GRID; i++)
          for (int j = 0; j < GRID; j++) begin mArena[i][j] = 0; mBomb[i][j] = 0; end
        mArena[1][1] = 2;
        mArena[GRID-2][GRID-2] = 3;
        if (blkOn) mArena[blkX][blkY] = 1;
        for (int k = c; k < c + 12; k++) begin
          eBusy[k] = 0; eWr[k] = 0; eBw[k] = 0; eAckA[k] = 0; eAckB[k] = 0;
          eOk[k] = 0; eRdV[k] = 0; ePosV[k] = 0;
        end
      end else begin
        if (bomb_done_a && mCnt[0] > 0) mCnt[0]--;
        if (bomb_done_b && mCnt[1] > 0) mCnt[1]--;
        if (c >= mFree && enable && (req_a || req_b)) begin
          p   = (req_a && req_b) ? (mLastB ? 0 : 1) : (req_b ? 1 : 0);
          cmd = p ? int'(cmd_b) : int'(cmd_a);
          x = mX[p]; y = mY[p]; tx = x; ty = y; bad = 0; okv = 0;
          case (cmd)
            0: ty = y - 1;
            1: ty = y + 1;
            2: tx = x - 1;
            3: tx = x + 1;
            4: ;
            default: bad = 1;
          endcase
          if (tx < 0 || tx > GRID - 1 || ty < 0 || ty > GRID - 1) bad = 1;
          if (bad) lat = 2;
          else begin
            eRdV[c+1] = 1; eRdX[c+1] = tx; eRdY[c+1] = ty;
            if (cmd == 4) begin
              if (mBomb[x][y] == 0 && mCnt[p] < 3) begin
                lat = 4; okv = 1; mCnt[p]++; mBomb[x][y] = 1 + p;
                eBw[c+3] = 1; eBx[c+3] = x; eBy[c+3] = y; eBo[c+3] = p;
              end else lat = 3;
            end else if (mArena[tx][ty] == 0 && mBomb[tx][ty] == 0) begin
              lat = 5; okv = 1;
              mArena[x][y] = 0; mArena[tx][ty] = 2 + p; mX[p] = tx; mY[p] = ty;
              eWr[c+3] = 1; eWrX[c+3] = x;  eWrY[c+3] = y;  eWrD[c+3] = 0;
              eWr[c+4] = 1; eWrX[c+4] = tx; eWrY[c+4] = ty; eWrD[c+4] = 2 + p;
              ePosV[c+5] = 1; ePosP[c+5] = p; ePosX[c+5] = tx; ePosY[c+5] = ty;
            end else lat = 3;
          end
          for (int k = 1; k <= lat; k++) eBusy[c+k] = 1;
          if (p == 0) eAckA[c+lat] = 1; else eAckB[c+lat] = 1;
          eOk[c+lat] = okv;
          mFree = c + lat + 1;
          mLastB = (p == 1);
        end
      end

      if (ePosV[c]) begin dX[ePosP[c]] = ePosX[c]; dY[ePosP[c]] = ePosY[c]; end
      chk("strobes{busy,ackA,ackB,wr,bomb}", {busy, ack_a, ack_b, wr_en, bomb_wr},
          {eBusy[c], eAckA[c], eAckB[c], eWr[c], eBw[c]});
      chk("positions{pax,pay,pbx,pby}", {pax, pay, pbx, pby},
          {4'(dX[0]), 4'(dY[0]), 4'(dX[1]), 4'(dY[1])});
      chk("single_write", {31'd0, wr_en && bomb_wr}, 32'd0);
      if (eWr[c]) chk("wr{x,y,data}", {wr_x, wr_y, wr_data}, {4'(eWrX[c]), 4'(eWrY[c]), 2'(eWrD[c])});
      if (eBw[c]) chk("bomb{x,y,owner}", {bomb_x, bomb_y, bomb_owner}, {4'(eBx[c]), 4'(eBy[c]), 1'(eBo[c])});
      if (eAckA[c] || eAckB[c]) chk("ok", {31'd0, ok}, {31'd0, eOk[c]});
      if (eRdV[c]) chk("rd{x,y}", {rd_x, rd_y}, {4'(eRdX[c]), 4'(eRdY[c])});
    end
    if (ack_a) begin ackCnt[0]++; lastAck[0] = c; lastOk[0] = int'(ok); ackLog.push_back(0); end
    if (ack_b) begin ackCnt[1]++; lastAck[1] = c; lastOk[1] = int'(ok); ackLog.push_back(1); end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetAll(input bit blk, input int bx, input int by);
    tick();
    blkOn = blk; blkX = bx; blkY = by;
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; enable = 1'b1;
    bomb_done_a = 1'b0; bomb_done_b = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic doOp(input int p, input int cmd, input bit dropEn, output int lat, output int okv);
    int n0, t0;
    n0 = ackCnt[p];
    if (p == 0) begin req_a = 1'b1; cmd_a = 3'(cmd); end
    else        begin req_b = 1'b1; cmd_b = 3'(cmd); end
    t0 = cyc;
    for (int i = 0; i < 40 && ackCnt[p] == n0; i++) begin
      tick();
      if (dropEn && i == 1) enable = 1'b0;
    end
    enable = 1'b1;
    if (p == 0) req_a = 1'b0; else req_b = 1'b0;
    chk("ack_arrives", ackCnt[p] - n0, 1);
    lat = lastAck[p] - t0;
    okv = lastOk[p];
  endtask

  task automatic pulseDone(input int p);
    if (p == 0) bomb_done_a = 1'b1; else bomb_done_b = 1'b1;
    tick();
    bomb_done_a = 1'b0; bomb_done_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, okv, n0, base;
    rst = 1'b0; enable = 1'b0; req_a = 1'b0; req_b = 1'b0;
    cmd_a = 3'd0; cmd_b = 3'd0; bomb_done_a = 1'b0; bomb_done_b = 1'b0;
    blkOn = 1'b0; blkX = 0; blkY = 0;
    ackCnt[0] = 0; ackCnt[1] = 0; lastAck[0] = 0; lastAck[1] = 0; lastOk[0] = 0; lastOk[1] = 0;

    // Reset state and enable gating
    resetAll(1'b0, 0, 0);
    chk("reset_rd_addr", {rd_x, rd_y}, 8'h00);
    chk("reset_wr_addr", {wr_x, wr_y}, 8'h00);
    chk("reset_pb", {pbx, pby}, 8'h88);
    enable = 1'b0; req_a = 1'b1; cmd_a = 3'd1;
    repeat (5) tick();
    chk("no_grant_when_disabled", {31'd0, busy}, 0);
    req_a = 1'b0; enable = 1'b1;
    tick();

    // A moves down; enable drops mid-op and the op still completes
    doOp(0, 1, 1'b1, lat, okv);
    chk("move_latency", lat, 5);
    chk("move_ok", okv, 1);
    chk("pay_after_down", {28'd0, pay}, 2);
    chk("map_old_cleared", {30'd0, envArena[1][1]}, 0);
    chk("map_new_set", {30'd0, envArena[1][2]}, 2);

    // Both held: strict alternation starting with A
    resetAll(1'b0, 0, 0);
    n0 = ackCnt[0] + ackCnt[1];
    base = ackLog.size();
    cmd_a = 3'd3; cmd_b = 3'd2; req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 200 && (ackCnt[0] + ackCnt[1] - n0) < 8; i++) tick();
    req_a = 1'b0; req_b = 1'b0;
    chk("both_ack_count", ackCnt[0] + ackCnt[1] - n0, 8);
    for (int i = 0; i < 8; i++)
      if (base + i < ackLog.size()) chk("alternation", ackLog[base+i], i % 2);
    chk("pax_after_4_right", {28'd0, pax}, 5);
    chk("pbx_after_4_left", {28'd0, pbx}, 4);
    tick();

    // Blocked move
    resetAll(1'b1, 0, 1);
    doOp(0, 2, 1'b0, lat, okv);
    chk("blocked_latency", lat, 3);
    chk("blocked_ok", okv, 0);
    chk("blocked_pax", {28'd0, pax}, 1);

    // Edge of the arena and reserved commands
    resetAll(1'b0, 0, 0);
    doOp(0, 2, 1'b0, lat, okv);
    chk("to_edge_latency", lat, 5);
    chk("pax_at_edge", {28'd0, pax}, 0);
    doOp(0, 2, 1'b0, lat, okv);
    chk("off_edge_latency", lat, 2);
    chk("off_edge_ok", okv, 0);
    chk("off_edge_no_read", {rd_x, rd_y}, 8'h01);
    doOp(0, 5, 1'b0, lat, okv);
    chk("reserved_latency", lat, 2);
    doOp(1, 3, 1'b0, lat, okv);
    doOp(1, 1, 1'b0, lat, okv);
    chk("pb_at_corner", {pbx, pby}, 8'h99);
    doOp(1, 3, 1'b0, lat, okv);
    chk("right_edge_latency", lat, 2);
    doOp(1, 1, 1'b0, lat, okv);
    chk("bottom_edge_ok", okv, 0);

    // Bomb limit, explosion credit, occupied cells, no underflow
    resetAll(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      doOp(1, 4, 1'b0, lat, okv);
      chk("bomb_latency", lat, 4);
      doOp(1, 2, 1'b0, lat, okv);
    end
    doOp(1, 4, 1'b0, lat, okv);
    chk("fourth_bomb_latency", lat, 3);
    chk("fourth_bomb_ok", okv, 0);
    pulseDone(1);
    tick();
    doOp(1, 4, 1'b0, lat, okv);
    chk("bomb_after_done_ok", okv, 1);
    doOp(1, 4, 1'b0, lat, okv);
    chk("bomb_on_bomb_ok", okv, 0);
    doOp(1, 3, 1'b0, lat, okv);
    chk("move_into_bomb_latency", lat, 3);
    chk("bomb_map_b", {30'd0, envBomb[8][8]}, 2);
    pulseDone(0);
    tick();
    doOp(0, 4, 1'b0, lat, okv);
    chk("no_underflow_ok", okv, 1);

    // Reset asserted during WR_CLR
    resetAll(1'b0, 0, 0);
    n0 = ackCnt[0];
    req_a = 1'b1; cmd_a = 3'd1;
    tick(); tick(); tick();
    chk("wr_en_before_reset", {31'd0, wr_en}, 1);
    rst = 1'b0;
    #1;
    chk("wr_en_async_drop", {31'd0, wr_en}, 0);
    chk("busy_async_drop", {31'd0, busy}, 0);
    chk("pa_reset", {pax, pay}, 8'h11);
    req_a = 1'b0;
    tick(); tick();
    rst = 1'b1;
    repeat (8) tick();
    chk("no_ack_after_reset", ackCnt[0] - n0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
